// File: rtl/m8c_issp_target.sv
// m8c_issp_target: target side of an M8C ISSP link.
// Decodes 22-bit host vectors clocked on SCLK into register write/read
// strobes, shifts read data back on SDATA, and runs the execute handshake
// (SDATA held high while busy, low when ready, released on the next clock).
module m8c_issp_target #(
    parameter logic [7:0] EXEC_ADDR = 8'hF0
) (
    input  logic       osc,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sdata_in,
    output logic       sdata_out,
    output logic       sdata_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       exec_start,
    input  logic       exec_done,
    output logic       frame_err
);

    // Vector decoder states
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_OPC        = 4'd1;
    localparam logic [3:0] S_ADDR       = 4'd2;
    localparam logic [3:0] S_WDATA      = 4'd3;
    localparam logic [3:0] S_WTRAIL     = 4'd4;
    localparam logic [3:0] S_RTURN1     = 4'd5;
    localparam logic [3:0] S_RDATA      = 4'd6;
    localparam logic [3:0] S_RTURN2     = 4'd7;
    localparam logic [3:0] S_RTRAIL     = 4'd8;
    localparam logic [3:0] S_SKIP       = 4'd9;
    localparam logic [3:0] S_EXEC_BUSY  = 4'd10;
    localparam logic [3:0] S_EXEC_READY = 4'd11;

    // Bit-counter values seen on the fall that ends each field
    // (the counter holds the number of vector bits already received).
    localparam logic [4:0] CNT_OPC_END   = 5'd2;
    localparam logic [4:0] CNT_ADDR_END  = 5'd10;
    localparam logic [4:0] CNT_WDATA_END = 5'd18;
    localparam logic [4:0] CNT_RDATA_END = 5'd19;
    localparam logic [4:0] CNT_VEC_END   = 5'd21;
    localparam logic [4:0] VEC_BITS      = 5'd22;

    localparam logic [2:0] OPC_WRITE = 3'b100;
    localparam logic [2:0] OPC_READ  = 3'b101;
    localparam logic [2:0] TRAIL_OK  = 3'b111;

    logic [1:0] sclk_sync;
    logic [1:0] sdata_sync;
    logic       sclk_prev;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       sbit;

    logic [3:0] state, state_d;
    logic [4:0] cnt, cnt_d, cnt_inc;
    logic [2:0] opc, opc_d;
    logic [7:0] addr_sh, addr_sh_d;
    logic [7:0] wdata_sh, wdata_sh_d;
    logic [2:0] trail, trail_d;
    logic [7:0] rd_sh, rd_sh_d;
    logic       seen_rise, seen_rise_d;
    logic [7:0] reg_addr_d, reg_wdata_d;
    logic       out_d, oe_d;
    logic       we_d, re_d, exec_d, ferr_d;

    // Two-stage synchronizers for SCLK/SDATA plus an SCLK history bit for edges
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            sdata_sync <= {sdata_sync[0], sdata_in};
            sclk_prev  <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign sbit      = sdata_sync[1];

    // Counter saturates at the vector length so it can never wrap mid-vector
    assign cnt_inc = (cnt == VEC_BITS) ? VEC_BITS : cnt + 5'd1;

    // Next-state and next-output decode; every field ends on a fixed count
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        opc_d       = opc;
        addr_sh_d   = addr_sh;
        wdata_sh_d  = wdata_sh;
        trail_d     = trail;
        rd_sh_d     = rd_sh;
        seen_rise_d = seen_rise;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        out_d       = sdata_out;
        oe_d        = sdata_oe;
        we_d        = 1'b0;
        re_d        = 1'b0;
        exec_d      = 1'b0;
        ferr_d      = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                // Zeros are idle filler; a 1 is the opcode MSB
                if (sclk_fall && sbit) begin
                    state_d = S_OPC;
                    cnt_d   = 5'd1;
                    opc_d   = 3'b001;
                end
            end

            S_OPC: begin
                if (sclk_fall) begin
                    opc_d = {opc[1:0], sbit};
                    cnt_d = cnt_inc;
                    if (cnt == CNT_OPC_END) begin
                        if (opc_d == OPC_WRITE || opc_d == OPC_READ) begin
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_SKIP;
                            ferr_d  = 1'b1;
                        end
                    end
                end
            end

            S_ADDR: begin
                if (sclk_fall) begin
                    addr_sh_d = {addr_sh[6:0], sbit};
                    cnt_d     = cnt_inc;
                    if (cnt == CNT_ADDR_END) begin
                        // reg_addr only changes once the whole address is in
                        reg_addr_d = addr_sh_d;
                        if (opc[0]) begin
                            state_d = S_RTURN1;
                            re_d    = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end

            S_WDATA: begin
                if (sclk_fall) begin
                    wdata_sh_d = {wdata_sh[6:0], sbit};
                    cnt_d      = cnt_inc;
                    if (cnt == CNT_WDATA_END) begin
                        reg_wdata_d = wdata_sh_d;
                        state_d     = S_WTRAIL;
                    end
                end
            end

            S_WTRAIL: begin
                if (sclk_fall) begin
                    trail_d = {trail[1:0], sbit};
                    cnt_d   = cnt_inc;
                    if (cnt == CNT_VEC_END) begin
                        if (trail_d == TRAIL_OK) begin
                            we_d = 1'b1;
                            if (reg_addr == EXEC_ADDR) begin
                                exec_d      = 1'b1;
                                state_d     = S_EXEC_BUSY;
                                oe_d        = 1'b1;
                                out_d       = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_RTURN1: begin
                if (sclk_fall) begin
                    cnt_d   = cnt_inc;
                    rd_sh_d = reg_rdata;
                    oe_d    = 1'b1;
                    out_d   = reg_rdata[7];
                    state_d = S_RDATA;
                end
            end

            S_RDATA: begin
                if (sclk_fall) begin
                    cnt_d = cnt_inc;
                    if (cnt == CNT_RDATA_END) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                        state_d = S_RTURN2;
                    end else begin
                        // rd_sh[7] is already on the pin; bring up the next bit
                        out_d   = rd_sh[6];
                        rd_sh_d = {rd_sh[6:0], 1'b0};
                    end
                end
            end

            S_RTURN2: begin
                if (sclk_fall) begin
                    cnt_d   = cnt_inc;
                    state_d = S_RTRAIL;
                end
            end

            S_RTRAIL: begin
                if (sclk_fall) begin
                    cnt_d   = cnt_inc;
                    state_d = S_IDLE;
                end
            end

            S_SKIP: begin
                if (sclk_fall) begin
                    cnt_d = cnt_inc;
                    if (cnt == CNT_VEC_END) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_EXEC_BUSY: begin
                oe_d  = 1'b1;
                out_d = 1'b1;
                if (exec_done) begin
                    out_d       = 1'b0;
                    seen_rise_d = 1'b0;
                    state_d     = S_EXEC_READY;
                end
            end

            S_EXEC_READY: begin
                oe_d  = 1'b1;
                out_d = 1'b0;
                if (sclk_rise) begin
                    seen_rise_d = 1'b1;
                end
                // Release only on a fall that follows a rise seen in this state
                if (sclk_fall && seen_rise) begin
                    oe_d        = 1'b0;
                    seen_rise_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                oe_d    = 1'b0;
                out_d   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered output update
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            opc        <= '0;
            addr_sh    <= '0;
            wdata_sh   <= '0;
            trail      <= '0;
            rd_sh      <= '0;
            seen_rise  <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            sdata_out  <= 1'b0;
            sdata_oe   <= 1'b0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            exec_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            opc        <= opc_d;
            addr_sh    <= addr_sh_d;
            wdata_sh   <= wdata_sh_d;
            trail      <= trail_d;
            rd_sh      <= rd_sh_d;
            seen_rise  <= seen_rise_d;
            reg_addr   <= reg_addr_d;
            reg_wdata  <= reg_wdata_d;
            sdata_out  <= out_d;
            sdata_oe   <= oe_d;
            reg_we     <= we_d;
            reg_re     <= re_d;
            exec_start <= exec_d;
            frame_err  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_m8c_issp_target.sv
// tb_m8c_issp_target: directed ISSP vectors against a vector-level model of
// the target (which strobes each vector must produce and which SDATA value
// the host must see in each SCLK high phase).
`timescale 1ns/1ps
module tb_m8c_issp_target;

    logic       osc = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       sdata_in = 1'b0;
    logic       exec_done = 1'b0;
    logic       sdata_out, sdata_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, exec_start, frame_err;

    // Register file seen by the DUT, and the bench's own copy of its contents
    logic [7:0] env_mem [256];
    logic [7:0] mdl_mem [256];

    int checks = 0;
    int failures = 0;
    int n_we = 0, n_re = 0, n_ex = 0, n_fe = 0;
    int s_we, s_re, s_ex, s_fe;
    logic [7:0] cap_addr = '0, cap_wdata = '0;
    logic       win = 1'b0, m_oe = 1'b0, m_out = 1'b0;
    logic       prev_we = 1'b0, prev_re = 1'b0, prev_ex = 1'b0, prev_fe = 1'b0;
    logic [7:0] rd_cap = '0;

    always #21 osc = ~osc;

    m8c_issp_target #(.EXEC_ADDR(8'hF0)) dut (
        .osc       (osc),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .sdata_in  (sdata_in),
        .sdata_out (sdata_out),
        .sdata_oe  (sdata_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .exec_start(exec_start),
        .exec_done (exec_done),
        .frame_err (frame_err)
    );

    assign reg_rdata = env_mem[reg_addr];
    always @(posedge osc) if (reg_we) env_mem[reg_addr] <= reg_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: SDATA against the model inside the host sample window,
    // strobe counting and one-cycle width of every strobe.
    always @(posedge osc) begin
        #1;
        if (rst_n) begin
            if (win) begin
                chk("sdata_oe", 32'(sdata_oe), 32'(m_oe));
                if (m_oe) chk("sdata_out", 32'(sdata_out), 32'(m_out));
            end
            if (reg_we) begin
                n_we++;
                cap_addr  = reg_addr;
                cap_wdata = reg_wdata;
                chk("we_width", 32'(prev_we), 32'd0);
            end
            if (reg_re) begin
                n_re++;
                chk("re_width", 32'(prev_re), 32'd0);
            end
            if (exec_start) begin
                n_ex++;
                chk("exec_width", 32'(prev_ex), 32'd0);
                chk("exec_with_we", 32'(reg_we), 32'd1);
            end
            if (frame_err) begin
                n_fe++;
                chk("ferr_width", 32'(prev_fe), 32'd0);
            end
        end
        prev_we = reg_we;
        prev_re = reg_re;
        prev_ex = exec_start;
        prev_fe = frame_err;
    end

    // One SCLK period: data set in the low phase, expectation armed for the
    // high phase, host samples SDATA mid-high; optional reset in the high phase.
    task automatic clock_bit(input logic b, input logic e_oe, input logic e_out, input logic abort_here);
        @(negedge osc);
        sdata_in = b;
        repeat (8) @(negedge osc);
        sclk  = 1'b1;
        m_oe  = e_oe;
        m_out = e_out;
        repeat (2) @(negedge osc);
        win = 1'b1;
        repeat (3) @(negedge osc);
        if (sdata_oe) rd_cap = {rd_cap[6:0], sdata_out};
        repeat (2) @(negedge osc);
        win = 1'b0;
        if (abort_here) begin
            rst_n = 1'b0;
            #1;
            chk("abort_oe_async", 32'(sdata_oe), 32'd0);
            chk("abort_addr", 32'(reg_addr), 32'd0);
            sclk     = 1'b0;
            sdata_in = 1'b0;
            repeat (3) @(negedge osc);
            rst_n = 1'b1;
            repeat (3) @(negedge osc);
            return;
        end
        @(negedge osc);
        sclk = 1'b0;
    endtask

    // Send a 22-bit vector MSB first; the target drives positions 12..19 of a read
    task automatic send_vector(input logic [21:0] v, input int abort_pos);
        logic [2:0] opc;
        logic [7:0] a;
        logic [7:0] rdv;
        logic       eo, ev;
        opc    = v[21:19];
        a      = v[18:11];
        rdv    = mdl_mem[a];
        rd_cap = '0;
        for (int p = 0; p < 22; p++) begin
            eo = (opc == 3'b101) && (p >= 12) && (p <= 19);
            ev = eo ? rdv[19 - p] : 1'b0;
            clock_bit(v[21 - p], eo, ev, p == abort_pos);
            if (p == abort_pos) return;
        end
        if (opc == 3'b100 && v[2:0] == 3'b111) mdl_mem[a] = v[10:3];
    endtask

    task automatic snap();
        s_we = n_we; s_re = n_re; s_ex = n_ex; s_fe = n_fe;
    endtask

    task automatic expect_strobes(input int we, input int re, input int ex, input int fe);
        repeat (6) @(negedge osc);
        chk("we_count", 32'(n_we - s_we), 32'(we));
        chk("re_count", 32'(n_re - s_re), 32'(re));
        chk("exec_count", 32'(n_ex - s_ex), 32'(ex));
        chk("ferr_count", 32'(n_fe - s_fe), 32'(fe));
    endtask

    // Send a vector and check the strobes the model says it must produce
    task automatic do_vector(input logic [21:0] v, input int abort_pos);
        logic [2:0] opc;
        logic [7:0] a;
        int we, re, ex, fe;
        opc = v[21:19];
        a   = v[18:11];
        we = 0; re = 0; ex = 0; fe = 0;
        if (abort_pos >= 0) begin
            re = (opc == 3'b101 && abort_pos > 10) ? 1 : 0;
        end else if (opc == 3'b100) begin
            if (v[2:0] == 3'b111) begin
                we = 1;
                ex = (a == 8'hF0) ? 1 : 0;
            end else begin
                fe = 1;
            end
        end else if (opc == 3'b101) begin
            re = 1;
        end else begin
            fe = 1;
        end
        snap();
        send_vector(v, abort_pos);
        expect_strobes(we, re, ex, fe);
        if (we == 1) begin
            chk("we_addr", 32'(cap_addr), 32'(a));
            chk("we_data", 32'(cap_wdata), 32'(v[10:3]));
        end
        if (opc == 3'b101 && abort_pos < 0) chk("read_bits", 32'(rd_cap), 32'(mdl_mem[a]));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i) ^ 8'h96;
            mdl_mem[i] = 8'(i) ^ 8'h96;
        end
        env_mem[8'h12] = 8'h5A;
        mdl_mem[8'h12] = 8'h5A;

        // Reset state
        repeat (4) @(negedge osc);
        chk("rst_oe", 32'(sdata_oe), 32'd0);
        chk("rst_out", 32'(sdata_out), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_strobes", 32'({reg_we, reg_re, exec_start, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge osc);

        // Plain write, then pin the model with literals
        do_vector({3'b100, 8'h3C, 8'hA5, 3'b111}, -1);
        chk("lit_addr", 32'(cap_addr), 32'h3C);
        chk("lit_wdata", 32'(cap_wdata), 32'hA5);
        chk("addr_held", 32'(reg_addr), 32'h3C);

        // Read of 0x12 must shift out 0,1,0,1,1,0,1,0; host turnaround/trailer 1s ignored
        do_vector({3'b101, 8'h12, 11'h7FF}, -1);
        chk("lit_read_5a", 32'(rd_cap), 32'h5A);

        // Read back the earlier write
        do_vector({3'b101, 8'h3C, 11'h000}, -1);
        chk("lit_read_a5", 32'(rd_cap), 32'hA5);

        // Bad opcode skipped, next write accepted
        do_vector({3'b110, 8'h55, 11'h7FF}, -1);
        do_vector({3'b100, 8'h20, 8'h77, 3'b111}, -1);

        // Bad trailer: no write, location keeps its old contents
        do_vector({3'b100, 8'h44, 8'h99, 3'b101}, -1);
        do_vector({3'b101, 8'h44, 11'h000}, -1);
        chk("lit_read_44", 32'(rd_cap), 32'(8'h44 ^ 8'h96));

        // Execute handshake
        do_vector({3'b100, 8'hF0, 8'h01, 3'b111}, -1);
        for (int i = 0; i < 60; i++) clock_bit(1'b0, 1'b1, 1'b1, 1'b0);
        exec_done = 1'b1;
        repeat (4) @(negedge osc);
        chk("ready_oe", 32'(sdata_oe), 32'd1);
        chk("ready_out", 32'(sdata_out), 32'd0);
        snap();
        clock_bit(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) clock_bit(1'b0, 1'b0, 1'b0, 1'b0);
        exec_done = 1'b0;
        expect_strobes(0, 0, 0, 0);

        // Reset during read data bit 4, then a clean write from IDLE
        do_vector({3'b101, 8'h12, 11'h7FF}, 15);
        do_vector({3'b100, 8'h55, 8'hC3, 3'b111}, -1);
        do_vector({3'b101, 8'h20, 11'h000}, -1);
        chk("lit_read_77", 32'(rd_cap), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
